// File: rtl/gtech_oa21_bist_pkg.sv
// gtech_bist_pkg: shared definitions for the OA21 cell BIST controller.
//   - bist_state_e      : controller FSM states (IDLE, APPLY, CHECK, DONE)
//   - OA21_TRUTH_TABLE  : expected Z for input index {A,B,C}; Z = (A | B) & C
//   - MISR_POLY         : feedback taps of x^8 + x^6 + x^5 + x^4 + 1 (x^8 implied)
//   - MISR_SEED         : signature value after reset and on every accepted start
//   - misr_step()       : one MISR clock, shifting in a single response bit
package gtech_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam logic [7:0] OA21_TRUTH_TABLE = 8'hA8;
  localparam logic [7:0] MISR_POLY        = 8'h71;
  localparam logic [7:0] MISR_SEED        = 8'hFF;

  // Galois-form step: shift left, fold the bit leaving bit 7 back through the
  // taps, and XOR the new response bit into bit 0.
  function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic din);
    logic [7:0] nxt;
    nxt = {sig[6:0], 1'b0};
    if (sig[7]) nxt = nxt ^ MISR_POLY;
    nxt[0] = nxt[0] ^ din;
    return nxt;
  endfunction

endpackage

// File: rtl/gtech_oa21_bist_misr.sv
// gtech_bist_misr: 8-bit single-input signature register.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (sig returns to MISR_SEED)
//   seed_load in   reload MISR_SEED (has priority over shift_en)
//   shift_en  in   fold din into the signature this cycle
//   din       in   response bit
//   sig       out  current signature
module gtech_bist_misr
  import gtech_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic       shift_en,
  input  logic       din,
  output logic [7:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (seed_load) begin
      sig <= MISR_SEED;
    end else if (shift_en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/gtech_oa21_bist.sv
// gtech_oa21_bist: exhaustive BIST controller for a 3-input OA21 cell.
// Walks all eight input vectors {A,B,C}, holds each for SETTLE_CYCLES cycles,
// then compares the cell response with TRUTH_TABLE for one cycle.
// Optional macro GTECH_OA21_BIST_MISR_EN adds an 8-bit response MISR and the
// signature output.
// Parameters:
//   TRUTH_TABLE    expected Z per vector index (bit n = Z for {A,B,C} == n)
//   SETTLE_CYCLES  hold cycles per vector before sampling, 1..15
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin a run; honoured only when idle
//   abort                 terminate a run at once; beats start when idle
//   dut_a, dut_b, dut_c   registered stimulus to the cell under test
//   dut_z                 cell response, looked at only in CHECK
//   busy                  run in progress (APPLY, CHECK, DONE)
//   done                  one-cycle pulse when a run completes normally
//   pass                  last completed run had no mismatches
//   err_cnt               mismatches of the last/current run (0..8)
//   first_fail_vec        index of the first mismatch; valid when err_cnt != 0
//   signature             MISR signature (macro builds only)
// Handshake: start/abort are level inputs sampled on each rising edge; there is
// no ready -- a start seen while busy is simply dropped.
module gtech_oa21_bist
  import gtech_bist_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE   = OA21_TRUTH_TABLE,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail_vec
`ifdef GTECH_OA21_BIST_MISR_EN
  ,
  output logic [7:0] signature
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_APPLY = ST_APPLY;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [3:0] settle, settle_nx;
  logic [2:0] stim;
  logic       start_ok;
  logic       abort_run;
  logic       mismatch;
  logic [3:0] err_nx;

  assign start_ok  = (state == S_IDLE) && start && !abort;
  assign abort_run = (state != S_IDLE) && abort;

  // Abort suppresses the compare so an aborted CHECK leaves the counts as
  // they were before that cycle.
  assign mismatch = (state == S_CHECK) && !abort && (dut_z != TRUTH_TABLE[idx]);
  assign err_nx   = err_cnt + {3'b000, mismatch};

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    settle_nx = settle;
    if (abort_run) begin
      state_nx  = S_IDLE;
      idx_nx    = 3'd0;
      settle_nx = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state_nx  = S_APPLY;
            idx_nx    = 3'd0;
            settle_nx = 4'd0;
          end
        end
        S_APPLY: begin
          if (settle == SETTLE_LAST) state_nx = S_CHECK;
          else                       settle_nx = settle + 4'd1;
        end
        S_CHECK: begin
          if (idx == 3'd7) begin
            state_nx = S_DONE;
          end else begin
            state_nx  = S_APPLY;
            idx_nx    = idx + 3'd1;
            settle_nx = 4'd0;
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
          idx_nx   = 3'd0;
        end
        default: begin
          state_nx = S_IDLE;
          idx_nx   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= 3'd0;
      settle <= 4'd0;
      stim   <= 3'd0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      settle <= settle_nx;
      // Stimulus is registered from the next-state view so it changes in the
      // same cycle the FSM enters APPLY, and stays put through CHECK.
      stim   <= ((state_nx == S_APPLY) || (state_nx == S_CHECK)) ? idx_nx : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= 4'd0;
      first_fail_vec <= 3'd0;
      pass           <= 1'b0;
    end else if (start_ok) begin
      err_cnt        <= 4'd0;
      first_fail_vec <= 3'd0;
      pass           <= 1'b0;
    end else if (abort_run) begin
      pass <= 1'b0;
    end else begin
      if (mismatch) begin
        err_cnt <= err_nx;
        if (err_cnt == 4'd0) first_fail_vec <= idx;
      end
      // pass is settled on the edge into DONE so it is already valid while
      // done is high.
      if ((state == S_CHECK) && (state_nx == S_DONE)) pass <= (err_nx == 4'd0);
    end
  end

  assign dut_a = stim[2];
  assign dut_b = stim[1];
  assign dut_c = stim[0];
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

`ifdef GTECH_OA21_BIST_MISR_EN
  gtech_bist_misr u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (start_ok),
    .shift_en  ((state == S_CHECK) && !abort),
    .din       (dut_z),
    .sig       (signature)
  );
`endif

endmodule

// File: tb/tb_gtech_oa21_bist.sv
// tb_gtech_oa21_bist: bench for gtech_oa21_bist with default parameters.
// The cell under test is modelled by a response table resp_tab: dut_z is
// resp_tab[{dut_a,dut_b,dut_c}]. Expected results follow directly from how
// resp_tab differs from the OA21 truth table. Build with
// +define+GTECH_OA21_BIST_MISR_EN to also check the signature.
module tb_gtech_oa21_bist;

  localparam logic [7:0] GOLD = 8'hA8;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       dut_a, dut_b, dut_c;
  logic       dut_z;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] first_fail_vec;
`ifdef GTECH_OA21_BIST_MISR_EN
  logic [7:0] signature;
`endif

  logic [7:0] resp_tab;
  int         vectors;
  int         miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_z = resp_tab[{dut_a, dut_b, dut_c}];

  gtech_oa21_bist dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .dut_a          (dut_a),
    .dut_b          (dut_b),
    .dut_c          (dut_c),
    .dut_z          (dut_z),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_fail_vec (first_fail_vec)
`ifdef GTECH_OA21_BIST_MISR_EN
    ,
    .signature      (signature)
`endif
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results for the current resp_tab.
  function automatic int exp_err();
    return $countones(resp_tab ^ GOLD);
  endfunction

  function automatic int exp_ffv();
    logic [7:0] diff;
    diff = resp_tab ^ GOLD;
    for (int n = 0; n < 8; n++) if (diff[n]) return n;
    return 0;
  endfunction

  function automatic logic [7:0] exp_sig();
    logic [7:0] s;
    s = 8'hFF;
    for (int n = 0; n < 8; n++) begin
      s = ((s << 1) & 8'hFF) ^ (s[7] ? 8'h71 : 8'h00) ^ {7'b0, resp_tab[n]};
    end
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  // Launch a run and count cycles from the start edge until done is seen.
  task automatic run(input bit mid_start, output int lat, output bit got);
    got = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    while (lat < 100) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = (mid_start && lat == 10);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input bit mid_start);
    int lat;
    bit got;
    run(mid_start, lat, got);
    chk({tag, "_done"}, got, 1);
    chk({tag, "_lat"}, lat, 25);
    chk({tag, "_pass"}, pass, (exp_err() == 0));
    chk({tag, "_err"}, err_cnt, exp_err());
    chk({tag, "_ffv"}, first_fail_vec, exp_ffv());
`ifdef GTECH_OA21_BIST_MISR_EN
    chk({tag, "_sig"}, signature, exp_sig());
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_ffv"}, first_fail_vec, 0);
    chk({tag, "_stim"}, {dut_a, dut_b, dut_c}, 0);
`ifdef GTECH_OA21_BIST_MISR_EN
    chk({tag, "_sig"}, signature, 8'hFF);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  n;
    bit  saw;
`ifdef GTECH_OA21_BIST_MISR_EN
    logic [7:0] gold_sig;
`endif
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    resp_tab    = GOLD;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // golden cell
    resp_tab = GOLD;
    run_check("golden", 1'b0);
`ifdef GTECH_OA21_BIST_MISR_EN
    gold_sig = signature;
`endif

    // stuck-at-0 and stuck-at-1 cells
    resp_tab = 8'h00;
    run_check("stuck0", 1'b0);
`ifdef GTECH_OA21_BIST_MISR_EN
    chk("stuck0_sig_differs", (signature != gold_sig), 1);
`endif
    resp_tab = 8'hFF;
    run_check("stuck1", 1'b0);

    // results hold after DONE
    repeat (5) @(negedge clk);
    chk("hold_err", err_cnt, 5);
    chk("hold_ffv", first_fail_vec, 0);
    chk("hold_pass", pass, 0);

    // random faulty cells
    for (int i = 0; i < 6; i++) begin
      resp_tab = 8'($urandom_range(0, 255));
      run_check("random", 1'b0);
    end

    // start pulsed mid-run is ignored
    resp_tab = GOLD;
    run_check("midstart", 1'b1);

    // abort during APPLY of vector 4 with a stuck-at-0 cell
    resp_tab = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (({dut_a, dut_b, dut_c} != 3'b100) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_vec4", (n < 100), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_stim", {dut_a, dut_b, dut_c}, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", err_cnt, 1);
    chk("abort_ffv", first_fail_vec, 3);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    chk("abort_no_done", saw, 0);
    resp_tab = GOLD;
    run_check("after_abort", 1'b0);

    // start and abort together while idle: stay idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    saw = busy;
    repeat (3) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    chk("start_abort_idle", saw, 0);

    // reset mid-run discards the run
    resp_tab = 8'hFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk); rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    chk("midreset_no_done", saw, 0);

    // a clean run still works afterwards
    resp_tab = GOLD;
    run_check("final", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gtech_oa21_bist.md
GTECH_OA21_BIST -- requirements
Module: gtech_oa21_bist

Interface
REQ-001 SHALL provide parameter TRUTH_TABLE, default 8'hA8, expected output per input index {A,B,C} (bit n = expected Z for vector n).
REQ-002 SHALL provide parameter SETTLE_CYCLES, default 2, cycles each vector is held before sampling; legal range 1..15.
REQ-003 SHALL provide ports, one per line:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin test run (sampled in IDLE only)
- abort  input  1  terminate run immediately
- dut_a, dut_b, dut_c  output  1 each  registered stimulus to cell under test
- dut_z  input  1  cell response
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at normal run completion
- pass  output  1  last completed run had zero mismatches
- err_cnt  output  4  mismatch count of last/current run, 0..8
- first_fail_vec  output  3  index of first mismatching vector; valid when err_cnt != 0
- signature  output  8  MISR signature (present only with REQ-019 macro)

Function
REQ-004 SHALL implement FSM states IDLE, APPLY, CHECK, DONE.
REQ-005 IDLE: dut_a/b/c = 0, busy = 0; start=1 and abort=0 -> APPLY, vector index = 0, err_cnt = 0, pass = 0, first_fail_vec = 0.
REQ-006 APPLY: dut_{a,b,c} = vector index bits {2,1,0}; held exactly SETTLE_CYCLES cycles, then -> CHECK.
REQ-007 CHECK (1 cycle): dut_z compared to TRUTH_TABLE[index]; mismatch increments err_cnt; first mismatch of run loads first_fail_vec; stimulus held unchanged.
REQ-008 CHECK with index < 7 -> APPLY with index+1; index = 7 -> DONE.
REQ-009 DONE (1 cycle): done = 1, pass = (final err_cnt == 0), dut_* = 0; -> IDLE.
REQ-010 busy SHALL be 1 in APPLY, CHECK, DONE; 0 in IDLE.
REQ-011 Latency: start sampled at edge k -> done high in cycle k + 8*(SETTLE_CYCLES+1) + 1 (25 for default).
REQ-012 start while busy SHALL be ignored.
REQ-013 abort in any non-IDLE state SHALL force IDLE next cycle, dut_* = 0, pass = 0, no done pulse; err_cnt/first_fail_vec retain partial values.
REQ-014 start and abort simultaneously in IDLE: abort wins, remain IDLE.
REQ-015 pass, err_cnt, first_fail_vec SHALL hold after DONE until next accepted start.
REQ-016 dut_z SHALL be sampled only in CHECK; value in other states is don't-care.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, index 0, dut_* = 0, busy = 0, done = 0, pass = 0, err_cnt = 0, first_fail_vec = 0, signature = 8'hFF.
REQ-018 Reset mid-run SHALL discard the run; no done pulse after release.

Configuration
REQ-019 Macro GTECH_OA21_BIST_MISR_EN defined: 8-bit MISR, polynomial x^8+x^6+x^5+x^4+1, seeded 8'hFF on accepted start, shifts in dut_z every CHECK; signature port present and held after DONE.
REQ-020 Macro undefined: no MISR logic, no signature port; all other behaviour identical.

Structure
REQ-021 Shared package gtech_bist_pkg SHALL hold the FSM state enum, OA21 default truth table constant 8'hA8, MISR polynomial and seed constants.
REQ-022 MISR SHALL be sub-module gtech_bist_misr (clk, rst_n, seed_load, shift_en, din, sig), instantiated only under the macro.

Verification
REQ-023 Golden OA21 model on dut_z, defaults -> done at cycle 25 after start, pass=1, err_cnt=0.
REQ-024 dut_z stuck at 0 -> err_cnt=3, first_fail_vec=3, pass=0.
REQ-025 dut_z stuck at 1 -> err_cnt=5, first_fail_vec=0, pass=0.
REQ-026 abort asserted during APPLY of vector 4 -> busy=0 and dut_*=0 next cycle, no done, pass=0; a second start runs cleanly to pass=1.
REQ-027 start pulsed mid-run and rst_n pulsed mid-run -> first ignored (done still at cycle 25); second returns all outputs to reset values with no done.
REQ-028 With GTECH_OA21_BIST_MISR_EN: golden run signature equals reference-model value; stuck-at-0 run signature differs.
